// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the conv window sequencer.
//   conv_state_t  : layer sequencing states
//   tap_flags_t   : per-tap MAC control flags carried down the read-latency pipe
//   conv_out_dim  : output map size for one axis
//   cnt_w         : counter width for a 0..n-1 count (never below 1 bit)
package conv_pkg;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, WRITE, DONE} conv_state_t;

    typedef struct packed {
        logic en;
        logic clr;
        logic pad;
    } tap_flags_t;

    function automatic int conv_out_dim(input int in_sz, input int k, input int s, input int p);
        return (in_sz + 2 * p - k) / s + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// One level of a nested loop counter.
//   clk, rstn : clock, async active-low reset
//   step      : advance this level by one
//   count     : current index 0..LIMIT-1
//   wrap      : step taken on the last index (count returns to 0); steps the next outer level
module conv_loop_counter
    import conv_pkg::*;
#(
    parameter int LIMIT = 2,
    parameter int W     = cnt_w(LIMIT)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = step && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     count <= '0;
        else if (step) count <= wrap ? '0 : count + W'(1);
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences one convolution layer: one tap per cycle of pixel/weight BRAM reads,
// MAC clear/enable strobes aligned to the returning BRAM data, and one result
// write handshake per output pixel.
// Optional feature: define CONV_PAD_EN to honour PAD (out-of-map taps are not read
// and flagged with pad_zero); otherwise PAD is treated as 0.
// Ports:
//   clk, rstn          clock, async active-low reset
//   start              layer start pulse (accepted only in IDLE)
//   busy, done         layer in progress / one-cycle completion pulse
//   pic_en, pic_addr   pixel BRAM read
//   wgt_en, wgt_addr   weight BRAM read
//   mac_clr, mac_en    MAC load / accumulate, MEM_LAT after the read
//   pad_zero           current MAC tap is padding (use 0 as pixel)
//   out_valid/ready    result write handshake, out_addr stable while valid
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IN_CH      = 1,
    parameter int OUT_CH     = 6,
    parameter int IN_W       = 28,
    parameter int IN_H       = 28,
    parameter int K_W        = 5,
    parameter int K_H        = 5,
    parameter int STRIDE     = 1,
    parameter int PAD        = 0,
    parameter int MEM_LAT    = 1,
    parameter int MAC_LAT    = 1,
    parameter int ADDR_PIC_W = 10,
    parameter int ADDR_WGT_W = 9,
    parameter int ADDR_OUT_W = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pic_en,
    output logic [ADDR_PIC_W-1:0] pic_addr,
    output logic                  wgt_en,
    output logic [ADDR_WGT_W-1:0] wgt_addr,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  pad_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_OUT_W-1:0] out_addr
);

`ifdef CONV_PAD_EN
    localparam int PAD_E = PAD;
`else
    localparam int PAD_E = 0;
`endif
    localparam int OUT_W = conv_out_dim(IN_W, K_W, STRIDE, PAD_E);
    localparam int OUT_H = conv_out_dim(IN_H, K_H, STRIDE, PAD_E);
    localparam int TAPS  = IN_CH * K_H * K_W;
    localparam int FL    = MEM_LAT + MAC_LAT;
    localparam int FLW   = cnt_w(FL);

    // Pixel pointers use modular arithmetic: padded taps may point "below" the
    // map, but every address actually issued is in range and therefore exact.
    localparam logic [ADDR_PIC_W-1:0] PIC_ORG   = ADDR_PIC_W'(-(PAD_E * IN_W + PAD_E));
    localparam logic [ADDR_PIC_W-1:0] PIC_ROW   = ADDR_PIC_W'(IN_W);
    localparam logic [ADDR_PIC_W-1:0] PIC_PLANE = ADDR_PIC_W'(IN_H * IN_W);
    localparam logic [ADDR_PIC_W-1:0] PIC_XSTEP = ADDR_PIC_W'(STRIDE);
    localparam logic [ADDR_PIC_W-1:0] PIC_YSTEP = ADDR_PIC_W'(STRIDE * IN_W);
    localparam logic [ADDR_WGT_W-1:0] WGT_STEP  = ADDR_WGT_W'(TAPS);

    if (IN_CH * IN_H * IN_W > 2 ** ADDR_PIC_W) begin : g_chk_pic
        $error("conv_window_sequencer: ADDR_PIC_W too small for input map");
    end
    if (OUT_CH * TAPS > 2 ** ADDR_WGT_W) begin : g_chk_wgt
        $error("conv_window_sequencer: ADDR_WGT_W too small for weights");
    end
    if (PAD < 0 || MEM_LAT < 1 || MAC_LAT < 0) begin : g_chk_lat
        $error("conv_window_sequencer: bad PAD/MEM_LAT/MAC_LAT");
    end

    conv_state_t state, state_nx;
    logic [FLW-1:0] fl_cnt;
    logic run, win_step, tap_first, tap_pad;
    logic kx_wrap, ky_wrap, ic_wrap, ox_wrap, oy_wrap, oc_wrap;
    logic [cnt_w(K_W)-1:0]    kx;
    logic [cnt_w(K_H)-1:0]    ky;
    logic [cnt_w(IN_CH)-1:0]  ic;
    logic [cnt_w(OUT_W)-1:0]  ox;
    logic [cnt_w(OUT_H)-1:0]  oy;
    logic [cnt_w(OUT_CH)-1:0] oc;
    logic unused_cnt;

    assign run      = (state == RUN);
    assign win_step = (state == WRITE) && out_ready;

    // Tap loops advance every RUN cycle; window loops on each accepted result.
    conv_loop_counter #(.LIMIT(K_W))    u_kx (.clk(clk), .rstn(rstn), .step(run),      .count(kx), .wrap(kx_wrap));
    conv_loop_counter #(.LIMIT(K_H))    u_ky (.clk(clk), .rstn(rstn), .step(kx_wrap),  .count(ky), .wrap(ky_wrap));
    conv_loop_counter #(.LIMIT(IN_CH))  u_ic (.clk(clk), .rstn(rstn), .step(ky_wrap),  .count(ic), .wrap(ic_wrap));
    conv_loop_counter #(.LIMIT(OUT_W))  u_ox (.clk(clk), .rstn(rstn), .step(win_step), .count(ox), .wrap(ox_wrap));
    conv_loop_counter #(.LIMIT(OUT_H))  u_oy (.clk(clk), .rstn(rstn), .step(ox_wrap),  .count(oy), .wrap(oy_wrap));
    conv_loop_counter #(.LIMIT(OUT_CH)) u_oc (.clk(clk), .rstn(rstn), .step(oy_wrap),  .count(oc), .wrap(oc_wrap));

    // Window indices are only needed through their wrap pulses.
    assign unused_cnt = ^{ox, oy, oc};
    assign tap_first  = (kx == '0) && (ky == '0) && (ic == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            fl_cnt <= '0;
        end else begin
            state  <= state_nx;
            fl_cnt <= (state == FLUSH && fl_cnt != FLW'(FL - 1)) ? fl_cnt + FLW'(1) : '0;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (ic_wrap) state_nx = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (fl_cnt == FLW'(FL - 1)) state_nx = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = oc_wrap ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef CONV_PAD_EN
    // Window origin in map coordinates (may be negative at the top/left border).
    int wx, wy, ix, iy;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wx <= -PAD_E;
            wy <= -PAD_E;
        end else if (win_step) begin
            wx <= ox_wrap ? -PAD_E : wx + STRIDE;
            if (oy_wrap)      wy <= -PAD_E;
            else if (ox_wrap) wy <= wy + STRIDE;
        end
    end
    assign ix      = wx + int'(kx);
    assign iy      = wy + int'(ky);
    assign tap_pad = run && (ix < 0 || ix >= IN_W || iy < 0 || iy >= IN_H);
`else
    assign tap_pad = 1'b0;
`endif

    // Pixel address: window base -> channel plane -> kernel row -> tap, all by increments.
    logic [ADDR_PIC_W-1:0] row_base, win_base, win_nx, chan_ptr, line_ptr, pic_ptr, pic_hold;
    logic [ADDR_WGT_W-1:0] wgt_base, wgt_nx, wgt_ptr;
    logic [ADDR_OUT_W-1:0] out_ptr;

    always_comb begin
        win_nx = win_base + PIC_XSTEP;
        if (oy_wrap)      win_nx = PIC_ORG;
        else if (ox_wrap) win_nx = row_base + PIC_YSTEP;
        wgt_nx = wgt_base;
        if (oc_wrap)      wgt_nx = '0;
        else if (oy_wrap) wgt_nx = wgt_base + WGT_STEP;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_base <= PIC_ORG;
            win_base <= PIC_ORG;
            chan_ptr <= PIC_ORG;
            line_ptr <= PIC_ORG;
            pic_ptr  <= PIC_ORG;
            pic_hold <= '0;
            wgt_base <= '0;
            wgt_ptr  <= '0;
            out_ptr  <= '0;
        end else begin
            if (pic_en) pic_hold <= pic_ptr;
            if (win_step) begin
                if (ox_wrap) row_base <= win_nx;
                win_base <= win_nx;
                chan_ptr <= win_nx;
                line_ptr <= win_nx;
                pic_ptr  <= win_nx;
                wgt_base <= wgt_nx;
                wgt_ptr  <= wgt_nx;
                out_ptr  <= oc_wrap ? '0 : out_ptr + ADDR_OUT_W'(1);
            end else if (run) begin
                wgt_ptr <= wgt_ptr + ADDR_WGT_W'(1);
                // After the last tap the pointers are don't-care until the window reload.
                if (ky_wrap) begin
                    chan_ptr <= chan_ptr + PIC_PLANE;
                    line_ptr <= chan_ptr + PIC_PLANE;
                    pic_ptr  <= chan_ptr + PIC_PLANE;
                end else if (kx_wrap) begin
                    line_ptr <= line_ptr + PIC_ROW;
                    pic_ptr  <= line_ptr + PIC_ROW;
                end else begin
                    pic_ptr  <= pic_ptr + ADDR_PIC_W'(1);
                end
            end
        end
    end

    assign pic_en   = run && !tap_pad;
    assign pic_addr = pic_en ? pic_ptr : pic_hold;
    assign wgt_en   = run;
    assign wgt_addr = wgt_ptr;
    assign out_addr = out_ptr;

    // MAC strobes follow the read by MEM_LAT cycles so they line up with BRAM data.
    tap_flags_t tap_now;
    tap_flags_t vld_pipe [MEM_LAT:1];

    assign tap_now = '{en: run, clr: run && tap_first, pad: tap_pad};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i <= MEM_LAT; i++) vld_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= tap_now;
            for (int i = 2; i <= MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign mac_en   = vld_pipe[MEM_LAT].en;
    assign mac_clr  = vld_pipe[MEM_LAT].clr;
    assign pad_zero = vld_pipe[MEM_LAT].pad;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: 6x6 map, 3x3 kernel, 2 input and
// 2 output channels. Expected read/strobe/write timelines are derived per window
// and tap from the loop order and the coordinate/address formulas.
module tb_conv_window_sequencer;

    localparam int IN_CH = 2, OUT_CH = 2, IN_W = 6, IN_H = 6, K_W = 3, K_H = 3;
    localparam int STRIDE = 1, PAD = 1, MEM_LAT = 1, MAC_LAT = 1;
    localparam int APW = 10, AWW = 9, AOW = 12;
`ifdef CONV_PAD_EN
    localparam int PADE = PAD;
`else
    localparam int PADE = 0;
`endif
    localparam int OW   = (IN_W + 2 * PADE - K_W) / STRIDE + 1;
    localparam int OH   = (IN_H + 2 * PADE - K_H) / STRIDE + 1;
    localparam int TAPS = IN_CH * K_H * K_W;
    localparam int FLN  = MEM_LAT + MAC_LAT;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic busy, done, pic_en, wgt_en, mac_clr, mac_en, pad_zero, out_valid;
    logic [APW-1:0] pic_addr;
    logic [AWW-1:0] wgt_addr;
    logic [AOW-1:0] out_addr;

    conv_window_sequencer #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .IN_W(IN_W), .IN_H(IN_H), .K_W(K_W), .K_H(K_H),
        .STRIDE(STRIDE), .PAD(PAD), .MEM_LAT(MEM_LAT), .MAC_LAT(MAC_LAT),
        .ADDR_PIC_W(APW), .ADDR_WGT_W(AWW), .ADDR_OUT_W(AOW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .pic_en(pic_en), .pic_addr(pic_addr), .wgt_en(wgt_en), .wgt_addr(wgt_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .pad_zero(pad_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int last_pic = 0;
    logic [2:0] hist [$];  // {en, clr, pad} of each past cycle's read

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < MEM_LAT; i++) hist.push_back(3'b000);
        last_pic = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, done, 0);
        chk({tag, "_pic_en"}, pic_en, 0);     chk({tag, "_pic_addr"}, pic_addr, 0);
        chk({tag, "_wgt_en"}, wgt_en, 0);     chk({tag, "_wgt_addr"}, wgt_addr, 0);
        chk({tag, "_mac_clr"}, mac_clr, 0);   chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_pad_zero"}, pad_zero, 0); chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
    endtask

    // Check one cycle (at the falling edge), then drive inputs for the next rising edge.
    task automatic cyc(input bit rd, input bit pz, input bit first, input int paddr, input int waddr,
                       input bit ov, input int oaddr, input bit bsy, input bit dn,
                       input bit rdy, input bit st);
        logic [2:0] m;
        hist.push_back({rd, rd && first, rd && pz});
        m = hist.pop_front();
        chk("busy", busy, bsy);
        chk("done", done, dn);
        chk("pic_en", pic_en, rd && !pz);
        if (rd && !pz) begin
            chk("pic_addr", pic_addr, paddr);
            last_pic = paddr;
        end else begin
            chk("pic_addr_hold", pic_addr, last_pic);
        end
        chk("wgt_en", wgt_en, rd);
        if (rd) chk("wgt_addr", wgt_addr, waddr);
        chk("mac_en", mac_en, m[2]);
        chk("mac_clr", mac_clr, m[1]);
        chk("pad_zero", pad_zero, m[0]);
        chk("out_valid", out_valid, ov);
        if (ov) chk("out_addr", out_addr, oaddr);
        out_ready = rdy;
        start     = st;
        @(negedge clk);
    endtask

    function automatic bit noise_start(input bit en);
        return en && ($urandom_range(0, 3) == 0);
    endfunction

    // Full layer from IDLE; returns early (mid-RUN) when abort_at taps have been issued.
    task automatic run_layer(input bit rnd_rdy, input bit noise, input int abort_at, output bit aborted);
        int n, wi, kx, ky, ic, ix, iy, stall;
        bit pz, r;
        n = 0;
        aborted = 0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int oy = 0; oy < OH; oy++)
                for (int ox = 0; ox < OW; ox++) begin
                    wi = (oc * OH + oy) * OW + ox;
                    for (int t = 0; t < TAPS; t++) begin
                        kx = t % K_W;
                        ky = (t / K_W) % K_H;
                        ic = t / (K_W * K_H);
                        iy = oy * STRIDE + ky - PADE;
                        ix = ox * STRIDE + kx - PADE;
                        pz = (ix < 0) || (ix >= IN_W) || (iy < 0) || (iy >= IN_H);
                        if (n == abort_at) begin
                            aborted = 1;
                            return;
                        end
                        cyc(1, pz, t == 0, (ic * IN_H + iy) * IN_W + ix, oc * TAPS + t,
                            0, 0, 1, 0, 1, noise_start(noise));
                        n++;
                    end
                    for (int f = 0; f < FLN; f++)
                        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, noise_start(noise));
                    stall = (rnd_rdy && wi == 0) ? 5 : 0;
                    do begin
                        if (stall > 0) begin
                            r = 0;
                            stall--;
                        end else begin
                            r = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                        end
                        cyc(0, 0, 0, 0, 0, 1, wi, 1, 0, r, noise_start(noise));
                    end while (!r);
                end
        // DONE cycle: a start here must be ignored, then IDLE stays quiet.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, noise);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        reset_model();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        run_layer(0, 0, -1, ab);   // out_ready tied high
        run_layer(1, 1, -1, ab);   // random stalls plus stray start pulses

        // Abort mid-RUN with an asynchronous reset between clock edges.
        run_layer(0, 1, $urandom_range(5, 3 * TAPS), ab);
        start = 1'b0;
        #2 rstn = 1'b0;
        #1 check_zero("abort");
        @(negedge clk);
        check_zero("abort_hold");
        rstn = 1'b1;
        reset_model();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        run_layer(0, 0, -1, ab);   // fresh start after abort
        run_layer(1, 0, -1, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
